adder_tree_stream: RTL and testbench

ADDER_TREE_STREAM -- requirements
Module: adder_tree_stream

---
 rtl/adder_tree_stream.sv | 129 ++++++++++++
 tb/tb_adder_tree_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_stream.sv
// Streaming pipelined adder tree: registered input rank, L registered adder levels, and a
// frame accumulator/output rank. Every rank shifts together under a single advance enable.
module adder_tree_stream #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned N_IN   = 16,
   parameter int unsigned OUT_W  = 2 * DATA_W,
   parameter bit          SIGNED = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_IN*DATA_W-1:0]   inp,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic                     acc_mode,
   output logic                     in_ready,
   output logic [OUT_W-1:0]         outp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_overflow,
   output logic [7:0]               out_beats
);

   localparam int unsigned L  = $clog2(N_IN);
   localparam int unsigned TW = DATA_W + L;

   logic             advance;
   logic [L:0]       vld_q, last_q, mode_q;  // index k = tree level k, 0 = input register
   logic [TW-1:0]    tree_sum;
   logic [OUT_W-1:0] sum_ext, acc_q, res;
   logic [OUT_W:0]   add_full;
   logic             add_ovf, ovf_q, ovf_new, term;
   logic [7:0]       beats_q, beats_inc;

   // in_ready is combinational from out_ready through advance.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q  <= '0;
         last_q <= '0;
         mode_q <= '0;
      end else if (advance) begin
         vld_q  <= {vld_q[L-1:0], in_valid};
         last_q <= {last_q[L-1:0], in_last};
         mode_q <= {mode_q[L-1:0], acc_mode};
      end
   end

   for (genvar k = 0; k <= L; k++) begin : g_lvl
      localparam int W = DATA_W + k;
      localparam int N = N_IN >> k;
      logic [N*W-1:0] sum_q;

      if (k == 0) begin : g_in
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) sum_q <= '0;
            else if (advance) sum_q <= inp;
         end
      end else begin : g_add
         logic [N*W-1:0] sum_d;
         logic [W-2:0]   opa, opb;

         // Each pair is widened by one bit so the level can never overflow.
         always_comb begin
            sum_d = '0;
            opa   = '0;
            opb   = '0;
            for (int j = 0; j < N; j++) begin
               opa = g_lvl[k-1].sum_q[(2*j)*(W-1) +: W-1];
               opb = g_lvl[k-1].sum_q[(2*j+1)*(W-1) +: W-1];
               sum_d[j*W +: W] = {SIGNED & opa[W-2], opa} + {SIGNED & opb[W-2], opb};
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) sum_q <= '0;
            else if (advance) sum_q <= sum_d;
         end
      end
   end

   assign tree_sum = g_lvl[L].sum_q;

   always_comb begin
      sum_ext = '0;
      sum_ext[TW-1:0] = tree_sum;
      for (int i = TW; i < OUT_W; i++) sum_ext[i] = SIGNED & tree_sum[TW-1];
   end

   assign add_full  = {1'b0, acc_q} + {1'b0, sum_ext};
   assign res       = add_full[OUT_W-1:0];
   assign add_ovf   = SIGNED ? ((acc_q[OUT_W-1] == sum_ext[OUT_W-1]) &&
                                (res[OUT_W-1] != acc_q[OUT_W-1]))
                             : add_full[OUT_W];
   assign ovf_new   = ovf_q | add_ovf;
   assign beats_inc = (beats_q == 8'd255) ? 8'd255 : beats_q + 8'd1;
   assign term      = last_q[L] || !mode_q[L];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         beats_q      <= '0;
         outp         <= '0;
         out_valid    <= 1'b0;
         out_overflow <= 1'b0;
         out_beats    <= '0;
      end else if (advance) begin
         out_valid <= 1'b0;
         if (vld_q[L]) begin
            if (term) begin
               outp         <= res;
               out_valid    <= 1'b1;
               out_overflow <= ovf_new;
               out_beats    <= beats_inc;
               acc_q        <= '0;
               ovf_q        <= 1'b0;
               beats_q      <= '0;
            end else begin
               acc_q   <= res;
               ovf_q   <= ovf_new;
               beats_q <= beats_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_stream.sv
// Directed bench for adder_tree_stream: default signed, default unsigned and a small
// 8-bit/2-input signed instance, checked against hand-computed results.
module tb_adder_tree_stream;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [255:0] inp;
   logic         in_valid, in_last, acc_mode, out_ready;
   logic         in_ready, out_valid, out_overflow;
   logic [31:0]  outp;
   logic [7:0]   out_beats;

   logic         u_in_ready, u_out_valid, u_out_overflow;
   logic [31:0]  u_outp;
   logic [7:0]   u_out_beats;

   logic [15:0]  s_inp, s_outp;
   logic         s_in_valid, s_in_last, s_acc_mode, s_out_ready;
   logic         s_in_ready, s_out_valid, s_out_overflow;
   logic [7:0]   s_out_beats;

   int tests  = 0;
   int errors = 0;

   adder_tree_stream u_dut (
      .clk(clk), .reset(rst_n), .inp(inp), .in_valid(in_valid), .in_last(in_last),
      .acc_mode(acc_mode), .in_ready(in_ready), .outp(outp), .out_valid(out_valid),
      .out_ready(out_ready), .out_overflow(out_overflow), .out_beats(out_beats)
   );

   adder_tree_stream #(.SIGNED(1'b0)) u_uns (
      .clk(clk), .reset(rst_n), .inp(inp), .in_valid(in_valid), .in_last(in_last),
      .acc_mode(acc_mode), .in_ready(u_in_ready), .outp(u_outp), .out_valid(u_out_valid),
      .out_ready(out_ready), .out_overflow(u_out_overflow), .out_beats(u_out_beats)
   );

   adder_tree_stream #(.DATA_W(8), .N_IN(2), .OUT_W(16), .SIGNED(1'b1)) u_small (
      .clk(clk), .reset(rst_n), .inp(s_inp), .in_valid(s_in_valid), .in_last(s_in_last),
      .acc_mode(s_acc_mode), .in_ready(s_in_ready), .outp(s_outp), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_overflow(s_out_overflow), .out_beats(s_out_beats)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int i = 0; i < 16; i++) inp[i*16 +: 16] = v;
   endtask

   task automatic send(input logic [15:0] v, input logic last, input logic mode);
      set_all(v);
      in_valid = 1'b1;
      in_last  = last;
      acc_mode = mode;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n, accepted, k;
      logic ok, seen;

      rst_n = 1'b0;
      inp = '0; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0; out_ready = 1'b1;
      s_inp = '0; s_in_valid = 1'b0; s_in_last = 1'b0; s_acc_mode = 1'b0; s_out_ready = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outp", outp, 0);
      chk("rst_beats", out_beats, 0);
      chk("rst_ovf", out_overflow, 0);
      #20 rst_n = 1'b1;
      step();
      chk("rst_in_ready", in_ready, 1);

      // One beat of ones, standalone.
      send(16'h0001, 1'b0, 1'b0);
      wait_out(n);
      chk("ones_latency", n, 5);
      chk("ones_outp", outp, 32'h0000_0010);
      chk("ones_beats", out_beats, 1);
      chk("ones_ovf", out_overflow, 0);
      chk("ones_uns_outp", u_outp, 32'h0000_0010);

      // All 0xFFFF: -16 signed, 0xFFFF0 unsigned.
      send(16'hFFFF, 1'b0, 1'b0);
      wait_out(n);
      chk("neg_latency", n, 5);
      chk("neg_outp", outp, 32'hFFFF_FFF0);
      chk("neg_ovf", out_overflow, 0);
      chk("uns_outp", u_outp, 32'h000F_FFF0);
      chk("uns_ovf", u_out_overflow, 0);

      // Three-beat accumulation frame.
      send(16'h7FFF, 1'b0, 1'b1);
      send(16'h7FFF, 1'b0, 1'b1);
      send(16'h7FFF, 1'b1, 1'b1);
      wait_out(n);
      chk("acc3_latency", n, 5);
      chk("acc3_outp", outp, 32'h0017_FFD0);
      chk("acc3_beats", out_beats, 3);
      chk("acc3_ovf", out_overflow, 0);
      step();
      chk("acc3_single", out_valid, 0);

      // Backpressure: stream with out_ready low, then drain.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      acc_mode  = 1'b0;
      accepted  = 0;
      for (int c = 0; c < 10; c++) begin
         set_all(16'(accepted + 1));
         ok = in_ready;
         step();
         if (ok) accepted++;
      end
      chk("stall_accepted", accepted, 6);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold_outp", outp, 32'h10);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            chk("drain_order", outp, 64'(16 * (k + 1)));
            k++;
         end
         step();
      end
      chk("drain_count", k, 6);

      // Standalone beat mid-frame terminates it; bubbles in between change nothing.
      send(16'h0001, 1'b0, 1'b1);
      step();
      step();
      send(16'h0002, 1'b0, 1'b0);
      wait_out(n);
      chk("midterm_latency", n, 5);
      chk("midterm_outp", outp, 32'd48);
      chk("midterm_beats", out_beats, 2);
      step();

      // Reset while a result is held: output drops without a clock edge.
      out_ready = 1'b0;
      send(16'h0003, 1'b0, 1'b0);
      wait_out(n);
      chk("held_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_outp", outp, 0);
      chk("async_in_ready", in_ready, 1);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      // Reset with a partial frame in the accumulator.
      send(16'h0005, 1'b0, 1'b1);
      send(16'h0005, 1'b0, 1'b1);
      for (int c = 0; c < 8; c++) step();
      chk("partial_no_out", out_valid, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("partial_rst_valid", out_valid, 0);
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_ready", in_ready, 1);
      send(16'h0001, 1'b0, 1'b0);
      wait_out(n);
      chk("post_rst_outp", outp, 32'h0000_0010);
      chk("post_rst_beats", out_beats, 1);
      chk("post_rst_ovf", out_overflow, 0);
      step();

      // Small instance: 130 beats of 0x7F overflow 16-bit signed.
      seen = 1'b0;
      s_acc_mode = 1'b1;
      s_inp = 16'h7F7F;
      for (int b = 0; b < 130; b++) begin
         s_in_valid = 1'b1;
         s_in_last  = (b == 129);
         step();
         if (s_out_valid) seen = 1'b1;
      end
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
      n = 0;
      while (!s_out_valid && n < 10) begin
         step();
         n++;
      end
      chk("small_early", seen, 0);
      chk("small_latency", n, 2);
      chk("small_outp", s_outp, 16'h80FC);
      chk("small_ovf", s_out_overflow, 1);
      chk("small_beats", s_out_beats, 130);
      step();

      // Beat counter saturates at 255; overflow flag cleared from previous frame.
      s_inp = 16'h0101;
      for (int b = 0; b < 260; b++) begin
         s_in_valid = 1'b1;
         s_in_last  = (b == 259);
         step();
      end
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
      n = 0;
      while (!s_out_valid && n < 10) begin
         step();
         n++;
      end
      chk("sat_latency", n, 2);
      chk("sat_outp", s_outp, 16'h0208);
      chk("sat_beats", s_out_beats, 255);
      chk("sat_ovf", s_out_overflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
